// File: rtl/sudoku_cell_cursor.sv
// Mask-aware bidirectional cell cursor for the backtracking solver.
// Steps to the next/previous non-given cell and flags either grid end.
//
// Ports:
//   clock, reset (async, active-low)
//   start, dir   step request and direction (0 = forward, 1 = backward)
//   init         rescan forward from cell 0 inclusive; wins over start
//   fixed_mask   bit i set = cell i is a given, skipped by the scan
//   cursor       current cell index
//   busy         scan in progress
//   done         one-cycle completion pulse (success or end hit)
//   at_end       sticky: forward scan found no free cell
//   at_begin     sticky: backward scan found no free cell
module sudoku_cell_cursor #(
  parameter int CELLS = 81,
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             init,
  input  logic [CELLS-1:0] fixed_mask,
  output logic [WIDTH-1:0] cursor,
  output logic             busy,
  output logic             done,
  output logic             at_end,
  output logic             at_begin
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(CELLS - 1);
  localparam logic [CW-1:0] END_C = CW'(CELLS);

  state_t         state_q, state_d;
  logic [CW-1:0]  cand_q, cand_d;
  logic           dir_q, dir_d;
  logic [WIDTH-1:0] cursor_q, cursor_d;
  logic           done_q, done_d;
  logic           end_q, end_d;
  logic           begin_q, begin_d;

  logic [CW-1:0]  cur_ext;
  logic [CW-1:0]  cand_step;
  logic           in_range;
  logic           given;

  assign cur_ext   = {1'b0, cursor_q};
  assign cand_step = dir_q ? (cand_q - ONE) : (cand_q + ONE);

  // The extra top bit makes a backward underflow land far above
  // CELLS, so one unsigned compare covers both ends of the grid.
  assign in_range = (cand_q < END_C);

  // Mask lookup by compare, so an out-of-range cand never indexes.
  always_comb begin
    given = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (cand_q == CW'(i)) begin
        given = fixed_mask[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    dir_d    = dir_q;
    cursor_d = cursor_q;
    done_d   = 1'b0;
    end_d    = end_q;
    begin_d  = begin_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          cand_d  = '0;
          dir_d   = 1'b0;
          end_d   = 1'b0;
          begin_d = 1'b0;
          state_d = SCAN;
        end else if (start) begin
          end_d   = 1'b0;
          begin_d = 1'b0;
          dir_d   = dir;
          if (!dir) begin
            if (cur_ext == LAST) begin
              end_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              cand_d  = cur_ext + ONE;
              state_d = SCAN;
            end
          end else begin
            if (cur_ext == '0) begin
              begin_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              cand_d  = cur_ext - ONE;
              state_d = SCAN;
            end
          end
        end
      end
      SCAN: begin
        unique case (1'b1)
          !in_range: begin
            if (dir_q) begin
              begin_d = 1'b1;
            end else begin
              end_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = IDLE;
          end
          given: begin
            cand_d = cand_step;
          end
          default: begin
            cursor_d = cand_q[WIDTH-1:0];
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      dir_q    <= 1'b0;
      cursor_q <= '0;
      done_q   <= 1'b0;
      end_q    <= 1'b0;
      begin_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      dir_q    <= dir_d;
      cursor_q <= cursor_d;
      done_q   <= done_d;
      end_q    <= end_d;
      begin_q  <= begin_d;
    end
  end

  assign cursor   = cursor_q;
  assign busy     = (state_q == SCAN);
  assign done     = done_q;
  assign at_end   = end_q;
  assign at_begin = begin_q;

endmodule

// File: tb/tb_sudoku_cell_cursor.sv
// Directed, table-driven bench for sudoku_cell_cursor.
// Vectors run back to back; cursor state carries between them.
module tb_sudoku_cell_cursor;

  logic        clock;
  logic        reset;
  logic        start;
  logic        dir;
  logic        init;
  logic [80:0] fixed_mask;
  logic [6:0]  cursor;
  logic        busy;
  logic        done;
  logic        at_end;
  logic        at_begin;

  int checks;
  int failures;

  sudoku_cell_cursor #(
    .CELLS(81),
    .WIDTH(7)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .init      (init),
    .fixed_mask(fixed_mask),
    .cursor    (cursor),
    .busy      (busy),
    .done      (done),
    .at_end    (at_end),
    .at_begin  (at_begin)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        init;
    logic        start;
    logic        dir;
    logic        hold;
    logic [80:0] mask;
    int          exp_cursor;
    int          exp_busy;
    logic        exp_end;
    logic        exp_begin;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [80:0] lowmask(input int n);
    logic [80:0] m;
    m = '0;
    for (int i = 0; i < 81; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int idx, input string nm,
                      input logic i, input logic s,
                      input logic d, input logic h,
                      input logic [80:0] m, input int ec,
                      input int eb, input logic ee,
                      input logic eg);
    vecs[idx].name       = nm;
    vecs[idx].init       = i;
    vecs[idx].start      = s;
    vecs[idx].dir        = d;
    vecs[idx].hold       = h;
    vecs[idx].mask       = m;
    vecs[idx].exp_cursor = ec;
    vecs[idx].exp_busy   = eb;
    vecs[idx].exp_end    = ee;
    vecs[idx].exp_begin  = eg;
  endtask

  task automatic run(input vec_t v);
    int   bc;
    int   extra;
    logic seen;
    @(negedge clock);
    fixed_mask = v.mask;
    init       = v.init;
    start      = v.start;
    dir        = v.dir;
    @(posedge clock);
    #1;
    if (!v.hold) begin
      start = 1'b0;
      init  = 1'b0;
    end
    bc   = 0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
    start = 1'b0;
    init  = 1'b0;
    chk({v.name, " done_seen"}, int'(seen), 1);
    extra = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done || busy) extra++;
    end
    chk({v.name, " cursor"}, int'(cursor), v.exp_cursor);
    chk({v.name, " busy_cycles"}, bc, v.exp_busy);
    chk({v.name, " at_end"}, int'(at_end), int'(v.exp_end));
    chk({v.name, " at_begin"}, int'(at_begin), int'(v.exp_begin));
    chk({v.name, " extra_activity"}, extra, 0);
  endtask

  initial begin
    vec_t st;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    start      = 1'b0;
    dir        = 1'b0;
    init       = 1'b0;
    fixed_mask = '0;

    setv(0, "init10", 1, 0, 0, 0, lowmask(10), 10, 11, 0, 0);
    setv(1, "advance", 0, 1, 0, 0, '0, 11, 1, 0, 0);
    setv(2, "back1", 0, 1, 1, 0, '0, 10, 1, 0, 0);
    setv(3, "skipfwd", 0, 1, 0, 0,
         lowmask(14) & ~lowmask(11), 14, 4, 0, 0);
    setv(4, "init3", 1, 0, 0, 0, lowmask(3), 3, 4, 0, 0);
    setv(5, "backskip", 0, 1, 1, 0,
         lowmask(3) & ~lowmask(1), 0, 3, 0, 0);
    setv(6, "underflow", 0, 1, 1, 0,
         lowmask(3) & ~lowmask(1), 0, 0, 0, 1);
    setv(7, "init78", 1, 0, 0, 0, lowmask(78), 78, 79, 0, 0);
    setv(8, "overflow", 0, 1, 0, 0,
         lowmask(81) & ~lowmask(79), 78, 3, 1, 0);
    setv(9, "back77", 0, 1, 1, 0,
         lowmask(81) & ~lowmask(79), 77, 1, 0, 0);
    setv(10, "initwins", 1, 1, 1, 1, lowmask(5), 5, 6, 0, 0);
    setv(11, "initfull", 1, 0, 0, 0, lowmask(81), 5, 82, 1, 0);
    setv(12, "init80", 1, 0, 0, 0, lowmask(80), 80, 81, 0, 0);
    setv(13, "endimm", 0, 1, 0, 0, '0, 80, 0, 1, 0);
    setv(14, "holdback", 0, 1, 1, 1, '0, 79, 1, 0, 0);

    repeat (3) @(negedge clock);
    chk("rst cursor", int'(cursor), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst at_end", int'(at_end), 0);
    chk("rst at_begin", int'(at_begin), 0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run(vecs[i]);
    end

    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    st.name      = "step";
    st.init      = 1'b0;
    st.start     = 1'b1;
    st.dir       = 1'b0;
    st.hold      = 1'b0;
    st.mask      = '0;
    st.exp_busy  = 1;
    st.exp_end   = 1'b0;
    st.exp_begin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st.exp_cursor = i + 1;
      run(st);
    end

    @(negedge clock);
    fixed_mask = lowmask(61) & ~lowmask(6);
    start      = 1'b1;
    dir        = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("midscan busy", int'(busy), 1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort cursor", int'(cursor), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort at_end", int'(at_end), 0);
    chk("abort at_begin", int'(at_begin), 0);
    @(negedge clock);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sudoku_cell_cursor.md
# sudoku_cell_cursor

Bidirectional cell-index cursor for the solver's backtracking engine. On a step request it moves forward (advance after placing a digit) or backward (backtrack after exhausting a cell's candidates) to the next non-given cell. It skips cells marked fixed in the puzzle mask and flags running off either end of the grid. It is the down-counting, mask-aware counterpart of the solver's plain wrap-around up-counters: underflow and overflow are reported, never wrapped.

## Interface
- CELLS, 81, number of grid cells; valid indices 0..CELLS-1
- WIDTH, 7, cursor width; must satisfy 2**WIDTH >= CELLS+1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  step request; sampled only in IDLE
- dir  in  1  step direction: 0 = forward (index+1), 1 = backward (index-1); sampled with start
- init  in  1  rescan from cell 0 inclusive, forward; sampled only in IDLE; priority over start
- fixed_mask  in  CELLS  bit i = 1 means cell i is a given and must be skipped; must be stable while busy
- cursor  out  WIDTH  current cell index
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when a step or init completes, whether it succeeded or hit an end
- at_end  out  1  sticky: a forward scan found no free cell (puzzle solved)
- at_begin  out  1  sticky: a backward scan found no free cell (puzzle unsolvable)

## Operation
- Reset values: cursor=0, busy=0, done=0, at_end=0, at_begin=0, state=IDLE.
- States: IDLE, SCAN. Internal registers: cand (WIDTH+1 bits, signed-safe) and latched direction.
- IDLE with init=1: cand=0, direction forward, clear at_end and at_begin, busy=1, go to SCAN. start is ignored that cycle.
- IDLE with start=1 and init=0: clear both flags and latch dir.
  - Forward: if cursor==CELLS-1, set at_end and pulse done; no SCAN, busy stays 0, cursor unchanged. Otherwise cand=cursor+1, busy=1, go to SCAN.
  - Backward: if cursor==0, set at_begin and pulse done the same way. Otherwise cand=cursor-1, busy=1, go to SCAN.
- SCAN evaluates one candidate per cycle:
  - cand out of range (forward: cand==CELLS; backward: cand underflowed below 0): set at_end (forward) or at_begin (backward), pulse done, busy=0, go to IDLE. cursor is unchanged.
  - fixed_mask[cand]==1: step cand in the latched direction and stay in SCAN.
  - otherwise: cursor=cand, pulse done, busy=0, go to IDLE.
- start and init asserted while busy are ignored, not queued.
- Flags stay set until the next accepted start or init. done is never asserted for two consecutive cycles.
- Failed init (all cells fixed): at_end=1 and cursor is unchanged.
- Arithmetic: cand is compared before indexing, and fixed_mask is never indexed out of range.
- Reset asserted mid-scan aborts immediately and returns to the reset values.

## Timing
- Accepted start or init at edge k: busy=1 after edge k.
- Successful first candidate: at edge k+1, cursor updated, done=1, busy=0. Each skipped fixed cell adds one cycle.
- Worst case: CELLS+1 cycles from acceptance to done.
- Immediate end-of-grid on start (no SCAN): done and the flag are set at edge k itself, busy is never asserted, and a new start is accepted at edge k+1.
- After done, a new start can be accepted on the next edge; minimum step period is 2 cycles.
- Reset deassertion is synchronised by the system. The first start is honoured on the first rising edge after reset=1.

## Test plan
- Reset mid-scan: mask all zero, step 5 times forward, assert reset low while busy -> cursor=0, busy=0, flags=0 asynchronously.
- Plain advance: mask=0, cursor=10, start dir=0 -> cursor=11, done one cycle after busy; busy high exactly 1 cycle.
- Skip givens forward: cursor=10, mask bits 11,12,13 set, start dir=0 -> busy for 4 cycles, cursor=14, single done pulse.
- Backtrack with skip: cursor=3, mask bits 2,1 set, start dir=1 -> cursor=0; then start dir=1 again -> at_begin=1, done, busy never high, cursor=0.
- Overflow: cursor=78, mask bits 79,80 set, start dir=0 -> at_end=1 after 3 busy cycles, cursor stays 78. The next start dir=1 clears at_end and gives cursor=77.
- Init: mask bits 0..4 set, init=1 and start=1 together -> init wins, cursor=5 after 6 busy cycles. All 81 bits set -> at_end=1, cursor unchanged. A start held high throughout busy produces no extra step.
